// File: rtl/ale_line_streamer.sv
// Frame RAM to 24-bit pixel stream: PRELOAD_LINES burst, then one line per i_intr rising edge, then zero pad lines.
// Latency: start -> first rd_en 1 cycle, first valid pixel 2 cycles; pixel aligned with 1-cycle RAM read data.
// Backpressure: none on the pixel side; line requests buffered in a 2-bit saturating counter, overflow is sticky.
module ale_line_streamer #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PRELOAD_LINES = 4,
  parameter int PAD_LINES     = 2,
  parameter int ADDR_W        = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [23:0]       i_mem_data,
  output logic [23:0]       o_pixel_data,
  output logic              o_pixel_data_valid,
  input  logic              i_intr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int TOTAL = IMG_HEIGHT + PAD_LINES;
  localparam int LW    = $clog2(TOTAL + 1);
  localparam int CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   line;
  logic [CW-1:0]   col;
  logic [1:0]      pending;
  logic            intr_q;
  logic            pad_q;

  logic            intr_edge;
  logic            req;
  logic            take;
  logic            last_col;
  logic            in_img;
  logic            start_ok;
  logic [LW-1:0]   line_nx;

  assign intr_edge = i_intr & ~intr_q;
  assign req       = intr_edge && (state == FETCH || state == WAIT);
  assign take      = (state == WAIT) && (pending != 2'd0);
  assign last_col  = (col == CW'(IMG_WIDTH - 1));
  assign in_img    = (line < LW'(IMG_HEIGHT));
  assign start_ok  = i_start && (state == IDLE || state == DONE);
  assign line_nx   = line + LW'(1);

  // RAM data arrives in the same cycle as the registered valid; pad lines mask it to zero.
  assign o_pixel_data = (o_pixel_data_valid && !pad_q) ? i_mem_data : 24'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      line               <= '0;
      col                <= '0;
      pending            <= 2'd0;
      intr_q             <= 1'b0;
      pad_q              <= 1'b0;
      o_mem_rd_en        <= 1'b0;
      o_mem_addr         <= '0;
      o_pixel_data_valid <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_overrun          <= 1'b0;
    end else begin
      intr_q             <= i_intr;
      o_pixel_data_valid <= (state == FETCH);
      pad_q              <= (state == FETCH) && !in_img;

      // A request and a consumption in the same cycle cancel out.
      if (req && !take) begin
        if (pending == 2'd3) o_overrun <= 1'b1;
        else                 pending   <= pending + 2'd1;
      end else if (take && !req) begin
        pending <= pending - 2'd1;
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state       <= FETCH;
            line        <= '0;
            col         <= '0;
            pending     <= 2'd0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= '0;
          end
        end
        FETCH: begin
          // Image lines are contiguous in memory, so a running address equals line*W+col.
          if (in_img) o_mem_addr <= o_mem_addr + ADDR_W'(1);
          if (last_col) begin
            col  <= '0;
            line <= line_nx;
            if (line_nx == LW'(TOTAL)) begin
              state       <= DONE;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_mem_rd_en <= 1'b0;
            end else if (line_nx < LW'(PRELOAD_LINES)) begin
              o_mem_rd_en <= (line_nx < LW'(IMG_HEIGHT));
            end else begin
              state       <= WAIT;
              o_mem_rd_en <= 1'b0;
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        WAIT: begin
          if (take) begin
            state       <= FETCH;
            o_mem_rd_en <= in_img;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ale_line_streamer.sv
// Randomised-data scoreboard bench for ale_line_streamer: stimulus pushes expected lines, a negedge monitor pops and checks.
module tb_ale_line_streamer;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int P   = 4;
  localparam int PAD = 2;
  localparam int AW  = 18;

  typedef struct {
    logic [23:0] data;
    int          line;
    int          col;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_intr = 1'b0;
  logic          o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [23:0]   i_mem_data = 24'd0;
  logic [23:0]   o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_overrun;

  ale_line_streamer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(P), .PAD_LINES(PAD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_intr(i_intr), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [W*H];
  always @(posedge clk)
    if (o_mem_rd_en && int'(o_mem_addr) < W*H) i_mem_data <= mem[int'(o_mem_addr)];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = -10;
  int   n_valid = 0;
  pix_t exp_q[$];

  // Reference model state: next frame line to be requested, expected sticky overrun.
  int   next_line = 0;
  logic exp_overrun = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pix_t p;
    if (o_mem_rd_en) chk("rd_addr_in_image", longint'(int'(o_mem_addr) < W*H), 1);
    if (o_pixel_data_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel_count", exp_q.size(), 1);
      end else begin
        p = exp_q.pop_front();
        chk("pixel_data", o_pixel_data, p.data);
        if (p.col != 0)                    chk("line_contiguous", cyc - last_cyc, 1);
        else if (p.line > 0 && p.line < P) chk("preload_no_bubble", cyc - last_cyc, 1);
        else if (p.line >= P)              chk("gap_before_line", longint'(cyc - last_cyc >= 2), 1);
      end
      last_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected content of frame line L: RAM words for image lines, zeros for pad lines.
  task automatic push_line(input int l);
    pix_t p;
    for (int c = 0; c < W; c++) begin
      p.data = (l < H) ? mem[l*W + c] : 24'd0;
      p.line = l;
      p.col  = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    exp_overrun = 1'b0;
    for (int l = 0; l < P; l++) push_line(l);
    next_line = P;
  endtask

  task automatic pulse();
    i_intr = 1'b1;
    tick(1);
    i_intr = 1'b0;
    tick(1);
  endtask

  // k rapid requests while the streamer is busy fetching: at most 3 can be held, the rest overrun.
  task automatic burst_req(input int k);
    int acc;
    for (int i = 0; i < k; i++) pulse();
    acc = (k > 3) ? 3 : k;
    if (k > 3) exp_overrun = 1'b1;
    for (int i = 0; i < acc; i++)
      if (next_line < H + PAD) begin
        push_line(next_line);
        next_line++;
      end
  endtask

  task automatic single_req(input int settle);
    pulse();
    if (next_line < H + PAD) begin
      push_line(next_line);
      next_line++;
    end
    tick(settle);
  endtask

  initial begin
    int base;
    bit found;
    for (int i = 0; i < W*H; i++) mem[i] = 24'($urandom);

    // Reset state
    tick(3);
    chk("reset_valid", o_pixel_data_valid, 0);
    chk("reset_data", o_pixel_data, 0);
    chk("reset_rd_en", o_mem_rd_en, 0);
    chk("reset_addr", o_mem_addr, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_overrun", o_overrun, 0);
    rst = 1'b0;
    tick(2);

    // Preload burst with no requests, then a start that must be ignored mid-frame
    start_frame();
    chk("busy_after_start", o_busy, 1);
    tick(60);
    chk("preload_count", n_valid, 32);
    chk("wait_busy", o_busy, 1);
    chk("wait_rd_en", o_mem_rd_en, 0);
    chk("wait_done", o_done, 0);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(40);
    chk("start_ignored_count", n_valid, 32);

    // Two spaced requests -> two image lines, two more -> pad lines and done
    for (int i = 0; i < 2; i++) single_req($urandom_range(21, 40));
    chk("image_lines_count", n_valid, 48);
    for (int i = 0; i < 2; i++) single_req($urandom_range(21, 40));
    chk("frame_total", n_valid, 64);
    chk("frame_done", o_done, 1);
    chk("frame_busy", o_busy, 0);
    chk("queue_drained_a", exp_q.size(), 0);

    // Restart from DONE; three requests during the preload burst are held
    base = n_valid;
    start_frame();
    chk("restart_done_clear", o_done, 0);
    tick(4);
    burst_req(3);
    tick(60);
    chk("held_requests_count", n_valid - base, 56);
    chk("held_overrun", o_overrun, exp_overrun);
    single_req(25);
    chk("held_frame_done", o_done, 1);
    chk("held_frame_total", n_valid - base, 64);

    // Five requests during preload: counter saturates, overrun sticks
    base = n_valid;
    start_frame();
    tick(4);
    burst_req(5);
    tick(60);
    chk("sat_count", n_valid - base, 56);
    chk("sat_overrun", o_overrun, exp_overrun);
    single_req(25);
    chk("sat_done", o_done, 1);
    chk("sat_overrun_sticky", o_overrun, 1);
    chk("queue_drained_c", exp_q.size(), 0);

    // Reset at column 3 of line 2, requests ignored in IDLE, then replay from address 0
    start_frame();
    chk("start_clears_overrun", o_overrun, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (o_mem_rd_en && o_mem_addr == AW'(19)) found = 1'b1;
      else tick(1);
    end
    chk("reach_line2_col3", found, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_valid", o_pixel_data_valid, 0);
    chk("midrst_data", o_pixel_data, 0);
    chk("midrst_rd_en", o_mem_rd_en, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_pixels_left", exp_q.size(), 32 - 19);
    exp_q.delete();
    pulse();
    tick(3);
    base = n_valid;
    start_frame();
    tick(60);
    chk("replay_preload", n_valid - base, 32);
    for (int i = 0; i < 4; i++) single_req(30);
    chk("replay_total", n_valid - base, 64);
    chk("replay_done", o_done, 1);
    chk("queue_drained_d", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
